mcycle_sequencer: RTL and testbench
===================================

// Module: mcycle_sequencer
// PURPOSE
//  T-state/M-cycle timing generator for the control unit. Produces the one-hot
//  o_Cycle_Step (T1..T4) and o_Cycle_Count (M-cycle index) buses consumed by
//  every per-opcode microcode block. Restarts the count when microcode signals
//  the overlapped opcode fetch, generates the IR load strobe, and handles boot
//  fetch, HALT/wake and bus stall.
// PARAMETERS
//  STEPS   default 4  T-states per M-cycle; width of o_Cycle_Step
//  CYCLES  default 8  max M-cycles per instruction; width of o_Cycle_Count
// PORTS
//  i_Clk          in   1       system clock, all state on rising edge
//  i_Rst_n        in   1       async active-low reset
//  i_Stall        in   1       freeze all sequencer state this clock (bus wait/DMA)
//  i_IR_Fetch     in   1       OR of all microcode o_IR_Fetch outputs
//  i_Halt         in   1       HALT opcode microcode request
//  i_Wake         in   1       pending enabled interrupt; exits HALT
//  o_Cycle_Step   out  STEPS   one-hot T-state
//  o_Cycle_Count  out  CYCLES  one-hot M-cycle; all-zero when microcode idle
//  o_Boot_Fetch   out  1       sequencer-owned opcode fetch in progress (PC->addr)
//  o_IR_Load      out  1       load IR from data bus this clock
//  o_MCycle_End   out  1       last T-state of M-cycle, not stalled
//  o_Halted       out  1       in HALT state
//  o_Overrun      out  1       sticky: count ran past CYCLES-1 (macro only)
// BEHAVIOUR
//  - Reset (async, i_Rst_n=0): step=1, count=0, state=BOOT, o_Boot_Fetch=1,
//    o_Halted=0, o_Overrun=0, o_IR_Load=0, o_MCycle_End=0.
//  - Step: rotate left each clock while !i_Stall; STEPS-1 wraps to bit0, in all states.
//  - end = step[STEPS-1] & !i_Stall; o_MCycle_End=end (comb). o_IR_Load comb,
//    o_Cycle_* / o_Boot_Fetch / o_Halted / o_Overrun registered.
//  - States: BOOT, RUN, HALT. Count is zero outside RUN.
//    BOOT: o_Boot_Fetch=1; on end -> o_IR_Load=1, RUN, count=bit0.
//    RUN: on end, priority order:
//      1. i_Halt & !i_Wake -> HALT, count=0, o_IR_Load=0.
//      2. i_IR_Fetch (incl. i_Halt&i_Wake: HALT skipped) -> o_IR_Load=1, count=bit0.
//      3. else count shifts left one bit; past bit CYCLES-1 see CONFIGURATION.
//    HALT: o_Halted=1, steps keep running; on end & i_Wake -> BOOT; i_Wake
//      outside end ignored until end.
//  - i_Stall holds step, count, state; o_IR_Load and o_MCycle_End forced 0.
//  - i_IR_Fetch/i_Halt are only sampled at end; mid-cycle toggles are ignored.
//  - Reset asserted mid-instruction: immediate return to reset values; no
//    IR load occurs for the aborted M-cycle.
// CONFIGURATION
//  MCYCLE_SEQ_OVERRUN_CHECK_EN:
//   defined   : shift past bit CYCLES-1 sets o_Overrun (sticky until reset),
//               count=0, state=BOOT (recovery fetch at current PC).
//   undefined : o_Overrun tied 0; count rotates from bit CYCLES-1 to bit0.
// TESTING
//  1. Reset release, no stall -> 4 clocks BOOT w/ o_Boot_Fetch=1, o_IR_Load on
//     4th clock, then o_Cycle_Count=8'h01, o_Cycle_Step=4'h1.
//  2. 2-M-cycle opcode: i_IR_Fetch=1 while count=8'h02 -> count 01->02->01,
//     o_IR_Load pulses once per 8 clocks, o_MCycle_End each 4th clock.
//  3. i_Stall=1 for 3 clocks at step=4'h4, count=8'h02 -> values held,
//     no o_IR_Load; sequence resumes unchanged; instruction takes 11 clocks.
//  4. i_Halt=1 at end, i_Wake=0 -> o_Halted=1, count=0; i_Wake pulse at step
//     4'h2 -> no exit until next end, then BOOT fetch, o_IR_Load, count=01.
//  5. i_Halt=1 & i_Wake=1 at end with i_IR_Fetch=1 -> HALT skipped,
//     o_IR_Load=1, count=01, o_Halted stays 0.
//  6. i_IR_Fetch held 0 for 8 M-cycles: with MCYCLE_SEQ_OVERRUN_CHECK_EN
//     o_Overrun=1, state BOOT; without it count wraps 8'h80->8'h01, o_Overrun=0.
//     Async reset mid-sequence -> all outputs at reset values same clock.

Source files
------------

// File: rtl/mcycle_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mcycle_sequencer
//  Description : T-state / M-cycle timing generator for the control unit.
//                Drives one-hot step/count buses, the IR load strobe, the
//                sequencer-owned boot fetch, HALT/wake handling and bus stall.
//                Optional macro MCYCLE_SEQ_OVERRUN_CHECK_EN enables the sticky
//                overrun flag with recovery fetch; otherwise the count wraps.
//  Revision    : 1.0  initial release
// ============================================================================
module mcycle_sequencer #(
    parameter int STEPS  = 4,
    parameter int CYCLES = 8
) (
    input  logic              i_Clk,
    input  logic              i_Rst_n,
    input  logic              i_Stall,
    input  logic              i_IR_Fetch,
    input  logic              i_Halt,
    input  logic              i_Wake,
    output logic [STEPS-1:0]  o_Cycle_Step,
    output logic [CYCLES-1:0] o_Cycle_Count,
    output logic              o_Boot_Fetch,
    output logic              o_IR_Load,
    output logic              o_MCycle_End,
    output logic              o_Halted,
    output logic              o_Overrun
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [CYCLES-1:0] C_COUNT_FIRST = {{(CYCLES-1){1'b0}}, 1'b1};
    localparam logic [STEPS-1:0]  C_STEP_FIRST  = {{(STEPS-1){1'b0}}, 1'b1};

    state_t              r_state;
    state_t              w_state_nxt;
    logic [STEPS-1:0]    r_step;
    logic [STEPS-1:0]    w_step_nxt;
    logic [CYCLES-1:0]   r_count;
    logic [CYCLES-1:0]   w_count_nxt;
    logic                w_end;
    logic                w_ir_load;
    logic                w_overrun_set;

    // State register: step ring, M-cycle ring and sequencer state.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state <= ST_BOOT;
            r_step  <= C_STEP_FIRST;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Next-state and strobe decode; decisions are only taken on an unstalled T-last.
    always_comb begin
        w_state_nxt   = r_state;
        w_step_nxt    = r_step;
        w_count_nxt   = r_count;
        w_ir_load     = 1'b0;
        w_overrun_set = 1'b0;
        w_end         = r_step[STEPS-1] & ~i_Stall;

        if (!i_Stall) begin
            w_step_nxt = {r_step[STEPS-2:0], r_step[STEPS-1]};
        end

        if (w_end) begin
            case (r_state)
                ST_BOOT: begin
                    w_ir_load   = 1'b1;
                    w_state_nxt = ST_RUN;
                    w_count_nxt = C_COUNT_FIRST;
                end
                ST_RUN: begin
                    if (i_Halt && !i_Wake) begin
                        w_state_nxt = ST_HALT;
                        w_count_nxt = '0;
                    end else if (i_IR_Fetch) begin
                        // Halt with a wake already pending falls through to the next fetch.
                        w_ir_load   = 1'b1;
                        w_count_nxt = C_COUNT_FIRST;
                    end else if (r_count[CYCLES-1]) begin
`ifdef MCYCLE_SEQ_OVERRUN_CHECK_EN
                        // Microcode never fetched: flag it and refetch at the current PC.
                        w_overrun_set = 1'b1;
                        w_count_nxt   = '0;
                        w_state_nxt   = ST_BOOT;
`else
                        w_count_nxt   = C_COUNT_FIRST;
`endif
                    end else begin
                        w_count_nxt = {r_count[CYCLES-2:0], 1'b0};
                    end
                end
                ST_HALT: begin
                    if (i_Wake) begin
                        w_state_nxt = ST_BOOT;
                    end
                end
                default: begin
                    w_state_nxt = ST_BOOT;
                    w_count_nxt = '0;
                end
            endcase
        end
    end

`ifdef MCYCLE_SEQ_OVERRUN_CHECK_EN
    logic r_overrun;

    // Sticky overrun flag, cleared only by reset.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_overrun_set) begin
            r_overrun <= 1'b1;
        end
    end

    assign o_Overrun = r_overrun;
`else
    logic w_unused;
    assign w_unused  = w_overrun_set;
    assign o_Overrun = 1'b0;
`endif

    assign o_Cycle_Step  = r_step;
    assign o_Cycle_Count = r_count;
    assign o_Boot_Fetch  = (r_state == ST_BOOT);
    assign o_Halted      = (r_state == ST_HALT);
    assign o_IR_Load     = w_ir_load;
    assign o_MCycle_End  = w_end;

endmodule
`default_nettype wire

// File: tb/tb_mcycle_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mcycle_sequencer
//  Description : Self-checking bench for mcycle_sequencer: integer-level
//                reference model compared every cycle, plus directed scenarios
//                with hand-computed literal expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mcycle_sequencer;

    localparam int C_STEPS  = 4;
    localparam int C_CYCLES = 8;
    localparam int C_BOOT = 0, C_RUN = 1, C_HALT = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic stall, irf, halt, wake;
    logic [C_STEPS-1:0]  cyc_step;
    logic [C_CYCLES-1:0] cyc_count;
    logic boot_fetch, ir_load, mc_end, halted, overrun;

    int total = 0;
    int bad   = 0;

    mcycle_sequencer #(.STEPS(C_STEPS), .CYCLES(C_CYCLES)) dut (
        .i_Clk         (clk),
        .i_Rst_n       (rst_n),
        .i_Stall       (stall),
        .i_IR_Fetch    (irf),
        .i_Halt        (halt),
        .i_Wake        (wake),
        .o_Cycle_Step  (cyc_step),
        .o_Cycle_Count (cyc_count),
        .o_Boot_Fetch  (boot_fetch),
        .o_IR_Load     (ir_load),
        .o_MCycle_End  (mc_end),
        .o_Halted      (halted),
        .o_Overrun     (overrun)
    );

    always #5 clk = ~clk;

    // Reference model: T-state index, M-cycle index and mode as plain integers.
    int m_mode, m_t, m_m;
    bit m_ovr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= C_BOOT;
            m_t    <= 0;
            m_m    <= 0;
            m_ovr  <= 1'b0;
        end else if (!stall) begin
            m_t <= (m_t + 1) % C_STEPS;
            if (m_t == C_STEPS - 1) begin
                if (m_mode == C_BOOT) begin
                    m_mode <= C_RUN;
                    m_m    <= 0;
                end else if (m_mode == C_RUN) begin
                    if (halt && !wake)       m_mode <= C_HALT;
                    else if (irf)            m_m    <= 0;
                    else if (m_m < C_CYCLES - 1) m_m <= m_m + 1;
                    else begin
`ifdef MCYCLE_SEQ_OVERRUN_CHECK_EN
                        m_ovr  <= 1'b1;
                        m_mode <= C_BOOT;
`else
                        m_m    <= 0;
`endif
                    end
                end else if (wake) begin
                    m_mode <= C_BOOT;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic [C_STEPS-1:0]  e_step;
        logic [C_CYCLES-1:0] e_count;
        logic e_end, e_load;
        e_step  = C_STEPS'(1) << m_t;
        e_count = (m_mode == C_RUN) ? (C_CYCLES'(1) << m_m) : '0;
        e_end   = rst_n && (m_t == C_STEPS - 1) && !stall;
        e_load  = e_end && ((m_mode == C_BOOT) ||
                  (m_mode == C_RUN && !(halt && !wake) && irf));
        total++;
        if (cyc_step !== e_step || cyc_count !== e_count ||
            boot_fetch !== (m_mode == C_BOOT) || halted !== (m_mode == C_HALT) ||
            overrun !== m_ovr || mc_end !== e_end || ir_load !== e_load) begin
            bad++;
            $display("FAIL model_cmp t=%0t got step=%h cnt=%h bf=%b hl=%b ov=%b end=%b ld=%b want step=%h cnt=%h bf=%b hl=%b ov=%b end=%b ld=%b",
                     $time, cyc_step, cyc_count, boot_fetch, halted, overrun, mc_end, ir_load,
                     e_step, e_count, (m_mode == C_BOOT), (m_mode == C_HALT), m_ovr, e_end, e_load);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    int loads, ends, load_idx, stalls, gap_last;
    bit done;

    initial begin
        rst_n = 1'b0; stall = 1'b0; irf = 1'b0; halt = 1'b0; wake = 1'b0;
        tick; tick;
        // Reset state
        chk("rst_step",  32'(cyc_step), 32'h1);
        chk("rst_count", 32'(cyc_count), 32'h0);
        chk("rst_boot",  32'(boot_fetch), 32'h1);
        chk("rst_flags", {28'h0, halted, overrun, ir_load, mc_end}, 32'h0);
        rst_n = 1'b1;

        // 1: boot fetch, IR load on the 4th clock
        tick; tick; tick;
        chk("boot_step4", 32'(cyc_step), 32'h8);
        chk("boot_load",  {30'h0, boot_fetch, ir_load}, 32'h3);
        tick;
        chk("boot_count", 32'(cyc_count), 32'h01);
        chk("boot_step1", 32'(cyc_step), 32'h1);
        chk("boot_done",  32'(boot_fetch), 32'h0);

        // 2: two-M-cycle opcode over 16 clocks
        loads = 0; ends = 0; gap_last = -1; load_idx = 0;
        for (int c = 0; c < 16; c++) begin
            irf = (cyc_count == 8'h02);
            #1;
            if (ir_load) begin
                loads++;
                if (gap_last >= 0) load_idx = c - gap_last;
                gap_last = c;
            end
            if (mc_end) ends++;
            tick;
        end
        irf = 1'b0;
        chk("op2_loads", 32'(loads), 32'd2);
        chk("op2_gap",   32'(load_idx), 32'd8);
        chk("op2_ends",  32'(ends), 32'd4);
        chk("op2_count", 32'(cyc_count), 32'h01);

        // 3: stall three clocks at step 4 of the second M-cycle
        stalls = 0; load_idx = -1; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            irf   = (cyc_count == 8'h02);
            stall = (cyc_count == 8'h02 && cyc_step == 4'h4 && stalls < 3);
            #1;
            if (stall) begin
                stalls++;
                chk("stall_hold", {cyc_step, cyc_count, 2'b0, ir_load, mc_end}, {4'h4, 8'h02, 4'h0});
            end
            if (ir_load) begin
                load_idx = c;
                done = 1'b1;
            end
            tick;
        end
        stall = 1'b0; irf = 1'b0;
        chk("stall_len", 32'(load_idx + 1), 32'd11);
        chk("stall_resume", {cyc_step, cyc_count}, {4'h1, 8'h01});

        // 4: HALT, wake raised at step 2, exit only at the next end
        halt = 1'b1;
        tick; tick; tick; tick;
        halt = 1'b0;
        chk("halt_enter", {halted, 3'b0, cyc_step, cyc_count}, {1'b1, 3'b0, 4'h1, 8'h00});
        tick;
        wake = 1'b1;
        tick;
        chk("halt_wait4", {halted, 3'b0, cyc_step}, {1'b1, 3'b0, 4'h4});
        tick;
        chk("halt_wait8", {halted, 3'b0, cyc_step}, {1'b1, 3'b0, 4'h8});
        tick;
        wake = 1'b0;
        chk("wake_boot", {boot_fetch, halted}, 32'h2);
        tick; tick; tick;
        chk("wake_load", 32'(ir_load), 32'h1);
        tick;
        chk("wake_count", 32'(cyc_count), 32'h01);

        // 5: halt with wake pending and fetch requested
        halt = 1'b1; wake = 1'b1; irf = 1'b1;
        tick; tick; tick;
        chk("hskip_load", {ir_load, halted}, 32'h2);
        tick;
        halt = 1'b0; wake = 1'b0; irf = 1'b0;
        chk("hskip_state", {halted, 3'b0, cyc_count}, {4'h0, 8'h01});

        // 6: no fetch for 8 M-cycles
        for (int i = 0; i < 28; i++) tick;
        chk("ovr_last", 32'(cyc_count), 32'h80);
        for (int i = 0; i < 4; i++) tick;
`ifdef MCYCLE_SEQ_OVERRUN_CHECK_EN
        chk("ovr_flag", {overrun, boot_fetch, 6'h0, cyc_count}, {2'b11, 6'h0, 8'h00});
`else
        chk("ovr_wrap", {overrun, boot_fetch, 6'h0, cyc_count}, {2'b00, 6'h0, 8'h01});
`endif
        tick; tick;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_step",  {cyc_step, cyc_count}, {4'h1, 8'h00});
        chk("arst_flags", {boot_fetch, halted, overrun, ir_load, mc_end}, 32'h10);
        tick;
        rst_n = 1'b1;

        // Mixed pseudo-random traffic, checked by the model only
        for (int i = 0; i < 200; i++) begin
            stall = ($urandom_range(0, 4) == 0);
            irf   = ($urandom_range(0, 2) == 0);
            halt  = ($urandom_range(0, 9) == 0);
            wake  = ($urandom_range(0, 3) == 0);
            tick;
        end
        stall = 1'b0; irf = 1'b0; halt = 1'b0; wake = 1'b0;
        tick; tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
